// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory load/fetch sequencer.
package imem_ctrl_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } imem_state_e;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/imem_load_ctrl_fetch_port.sv
// Fetch address check and registered one-cycle fetch response stage.
module imem_fetch_port
   import imem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = RV_NOP
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  fetch_req,
   input  logic [31:0]           fetch_addr,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  mem_read_enable,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   output logic                  fetch_valid,
   output logic [DATA_WIDTH-1:0] fetch_instr,
   output logic                  fetch_fault
);

   logic [29:0] widx;
   logic        fault;
   logic        issue;

   assign widx  = word_index(fetch_addr);
   // Word index bits above the memory depth mean the fetch lies outside the array.
   assign fault = (|fetch_addr[1:0]) | (|(widx >> ADDR_WIDTH));
   assign issue = run & fetch_req;

   assign mem_read_enable  = issue & ~fault;
   assign mem_read_address = mem_read_enable ? widx[ADDR_WIDTH-1:0] : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_valid <= 1'b0;
         fetch_fault <= 1'b0;
         fetch_instr <= '0;
      end else begin
         fetch_valid <= issue;
         fetch_fault <= issue & fault;
         if (issue)
            fetch_instr <= fault ? NOP_INSTR : mem_read_data;
      end
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction memory sequencer: loads a program from the loader stream, then
// serves core fetches; a reprogram request drains the fetch pipe and reloads.
//
// state | meaning
// LOAD  | core held, loader words written at wr_ptr
// RUN   | core released, fetches served with one-cycle latency
// DRAIN | core held, last fetch response emitted, load counters cleared
module imem_load_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = RV_NOP
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   input  logic                  prog_req,
   input  logic                  fetch_req,
   input  logic [31:0]           fetch_addr,
   output logic                  fetch_valid,
   output logic [DATA_WIDTH-1:0] fetch_instr,
   output logic                  fetch_fault,
   output logic                  core_hold,
   output logic                  load_full,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic                  mem_read_enable,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0] mem_write_data
);

   imem_state_e           state, state_next;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic                  accept;
   logic                  at_top;

   // The write pointer is the low bits of the load count; it never wraps
   // because the load stops at the top address.
   assign wr_ptr = words_loaded[ADDR_WIDTH-1:0];
   assign accept = (state == LOAD) & ld_valid & ld_ready;
   assign at_top = (wr_ptr == {ADDR_WIDTH{1'b1}});

   assign core_hold         = (state != RUN);
   assign mem_write_enable  = accept;
   assign mem_write_address = accept ? wr_ptr : '0;
   assign mem_write_data    = accept ? ld_data : '0;

   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (accept && (ld_last || at_top)) state_next = RUN;
         RUN:     if (prog_req) state_next = DRAIN;
         DRAIN:   state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= LOAD;
         ld_ready     <= 1'b0;
         words_loaded <= '0;
         load_full    <= 1'b0;
      end else begin
         state    <= state_next;
         ld_ready <= (state_next == LOAD);
         if (state == DRAIN) begin
            words_loaded <= '0;
         end else if (accept) begin
            words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
            if (at_top && !ld_last)
               load_full <= 1'b1;
            else if (wr_ptr == '0)
               load_full <= 1'b0;
         end
      end
   end

   imem_fetch_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NOP_INSTR  (NOP_INSTR)
   ) u_fetch_port (
      .clock            (clock),
      .reset            (reset),
      .run              (state == RUN),
      .fetch_req        (fetch_req),
      .fetch_addr       (fetch_addr),
      .mem_read_data    (mem_read_data),
      .mem_read_enable  (mem_read_enable),
      .mem_read_address (mem_read_address),
      .fetch_valid      (fetch_valid),
      .fetch_instr      (fetch_instr),
      .fetch_fault      (fetch_fault)
   );

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a default-size instance plus a 16-word instance for depth-limited loads.
module tb_imem_load_ctrl;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // default-size instance
   logic        reset, ld_valid, ld_last, prog_req, fetch_req;
   logic [31:0] ld_data, fetch_addr;
   logic        ld_ready, fetch_valid, fetch_fault, core_hold, load_full;
   logic [31:0] fetch_instr, mem_read_data, mem_write_data;
   logic [12:0] words_loaded;
   logic        mem_read_enable, mem_write_enable;
   logic [11:0] mem_read_address, mem_write_address;
   logic [31:0] mem [0:4095];

   // 16-word instance
   logic        reset_s, ld_valid_s, ld_last_s, prog_req_s, fetch_req_s;
   logic [31:0] ld_data_s, fetch_addr_s;
   logic        ld_ready_s, fetch_valid_s, fetch_fault_s, core_hold_s, load_full_s;
   logic [31:0] fetch_instr_s, mem_read_data_s, mem_write_data_s;
   logic [4:0]  words_loaded_s;
   logic        mem_read_enable_s, mem_write_enable_s;
   logic [3:0]  mem_read_address_s, mem_write_address_s;
   logic [31:0] mem_s [0:15];

   imem_load_ctrl dut (
      .clock(clock), .reset(reset),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .prog_req(prog_req), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
      .core_hold(core_hold), .load_full(load_full), .words_loaded(words_loaded),
      .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
      .mem_read_data(mem_read_data), .mem_write_enable(mem_write_enable),
      .mem_write_address(mem_write_address), .mem_write_data(mem_write_data)
   );

   imem_load_ctrl #(.ADDR_WIDTH(4)) dut_s (
      .clock(clock), .reset(reset_s),
      .ld_valid(ld_valid_s), .ld_data(ld_data_s), .ld_last(ld_last_s), .ld_ready(ld_ready_s),
      .prog_req(prog_req_s), .fetch_req(fetch_req_s), .fetch_addr(fetch_addr_s),
      .fetch_valid(fetch_valid_s), .fetch_instr(fetch_instr_s), .fetch_fault(fetch_fault_s),
      .core_hold(core_hold_s), .load_full(load_full_s), .words_loaded(words_loaded_s),
      .mem_read_enable(mem_read_enable_s), .mem_read_address(mem_read_address_s),
      .mem_read_data(mem_read_data_s), .mem_write_enable(mem_write_enable_s),
      .mem_write_address(mem_write_address_s), .mem_write_data(mem_write_data_s)
   );

   assign mem_read_data   = mem[mem_read_address];
   assign mem_read_data_s = mem_s[mem_read_address_s];

   always @(posedge clock) begin
      if (mem_write_enable)   mem[mem_write_address]     <= mem_write_data;
      if (mem_write_enable_s) mem_s[mem_write_address_s] <= mem_write_data_s;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] ld_words [4];
      ld_words = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      for (int i = 0; i < 16; i++) mem_s[i] = 32'h0;
      mem[5] = 32'hdead_beef;

      reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
      prog_req = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
      reset_s = 1'b0; ld_valid_s = 1'b0; ld_last_s = 1'b0; ld_data_s = '0;
      prog_req_s = 1'b0; fetch_req_s = 1'b0; fetch_addr_s = '0;

      repeat (2) @(negedge clock);
      #1;
      check("rst_core_hold", core_hold, 1);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_fetch_valid", fetch_valid, 0);
      check("rst_words_loaded", words_loaded, 0);
      check("rst_load_full", load_full, 0);
      check("rst_mem_we", mem_write_enable, 0);
      check("rst_mem_re", mem_read_enable, 0);

      @(negedge clock);
      reset = 1'b1; reset_s = 1'b1;
      #1;
      check("ready_first_cycle", ld_ready, 0);

      // load 4 words, last flagged on the 4th
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         ld_valid = 1'b1; ld_data = ld_words[i]; ld_last = (i == 3);
         #1;
         check("load_we", mem_write_enable, 1);
         check("load_waddr", mem_write_address, i);
         check("load_wdata", mem_write_data, ld_words[i]);
         check("load_hold", core_hold, 1);
      end
      @(negedge clock);
      ld_valid = 1'b0; ld_last = 1'b0;
      #1;
      check("run_core_hold", core_hold, 0);
      check("run_words_loaded", words_loaded, 4);
      check("run_load_full", load_full, 0);
      check("run_ld_ready", ld_ready, 0);

      // loader held off while running
      ld_valid = 1'b1; ld_data = 32'h99;
      #1;
      check("run_ld_no_write", mem_write_enable, 0);
      ld_valid = 1'b0;

      // back-to-back fetches
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         fetch_req = 1'b1; fetch_addr = 32'(4 * i);
         #1;
         check("b2b_re", mem_read_enable, 1);
         check("b2b_raddr", mem_read_address, i);
         if (i > 0) begin
            check("b2b_valid", fetch_valid, 1);
            check("b2b_instr", fetch_instr, ld_words[i-1]);
         end
      end
      @(negedge clock);
      fetch_req = 1'b0;
      #1;
      check("b2b_valid_last", fetch_valid, 1);
      check("b2b_instr_last", fetch_instr, 32'h33);
      check("b2b_fault_last", fetch_fault, 0);
      @(negedge clock);
      #1;
      check("idle_valid", fetch_valid, 0);

      // misaligned and out-of-range fetches
      fetch_req = 1'b1; fetch_addr = 32'h6;
      #1;
      check("mis_re", mem_read_enable, 0);
      @(negedge clock);
      fetch_addr = 32'h0000_4000;
      #1;
      check("mis_valid", fetch_valid, 1);
      check("mis_fault", fetch_fault, 1);
      check("mis_instr", fetch_instr, 32'h13);
      check("oor_re", mem_read_enable, 0);
      @(negedge clock);
      fetch_addr = 32'h14;
      #1;
      check("oor_valid", fetch_valid, 1);
      check("oor_fault", fetch_fault, 1);
      check("oor_instr", fetch_instr, 32'h13);
      check("beyond_loaded_re", mem_read_enable, 1);
      @(negedge clock);
      fetch_req = 1'b0;
      #1;
      check("beyond_loaded_fault", fetch_fault, 0);
      check("beyond_loaded_instr", fetch_instr, 32'hdead_beef);

      // reprogram with a fetch in the same cycle
      @(negedge clock);
      fetch_req = 1'b1; fetch_addr = 32'h8; prog_req = 1'b1;
      #1;
      check("prog_fetch_re", mem_read_enable, 1);
      @(negedge clock);
      fetch_addr = 32'h0; prog_req = 1'b0;
      #1;
      check("drain_valid", fetch_valid, 1);
      check("drain_instr", fetch_instr, 32'h33);
      check("drain_hold", core_hold, 1);
      check("drain_no_read", mem_read_enable, 0);
      @(negedge clock);
      fetch_req = 1'b0;
      #1;
      check("reload_valid", fetch_valid, 0);
      check("reload_words", words_loaded, 0);
      check("reload_ready", ld_ready, 1);
      check("reload_hold", core_hold, 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         ld_valid = 1'b1; ld_data = 32'haa + 32'(i * 17); ld_last = (i == 1);
         #1;
         check("reload_waddr", mem_write_address, i);
         check("reload_we", mem_write_enable, 1);
      end
      @(negedge clock);
      ld_valid = 1'b0; ld_last = 1'b0;
      fetch_req = 1'b1; fetch_addr = 32'h4;
      #1;
      check("reload_words_done", words_loaded, 2);
      check("reload_run", core_hold, 0);
      @(negedge clock);
      fetch_req = 1'b0;
      #1;
      check("reload_fetch", fetch_instr, 32'hbb);

      // reset in the middle of a load
      @(negedge clock);
      prog_req = 1'b1;
      @(negedge clock);
      prog_req = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1; ld_data = 32'h51 + 32'(i);
         @(negedge clock);
      end
      ld_data = 32'h53;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_hold", core_hold, 1);
      check("midrst_ready", ld_ready, 0);
      check("midrst_words", words_loaded, 0);
      check("midrst_we", mem_write_enable, 0);
      check("midrst_valid", fetch_valid, 0);
      @(negedge clock);
      reset = 1'b1; ld_valid = 1'b0;
      #1;
      check("midrst_ready_release", ld_ready, 0);
      @(negedge clock);
      ld_valid = 1'b1; ld_data = 32'h61; ld_last = 1'b1;
      #1;
      check("midrst_restart_addr", mem_write_address, 0);
      check("midrst_restart_we", mem_write_enable, 1);
      @(negedge clock);
      ld_valid = 1'b0; ld_last = 1'b0;
      fetch_req = 1'b1; fetch_addr = 32'h4;
      @(negedge clock);
      fetch_req = 1'b0;
      #1;
      check("midrst_kept_mem", fetch_instr, 32'h52);

      // depth-limited load on the 16-word instance
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         ld_valid_s = 1'b1; ld_data_s = 32'(i + 1); ld_last_s = 1'b0;
         #1;
         if (i < 16) begin
            check("full_we", mem_write_enable_s, 1);
            check("full_waddr", mem_write_address_s, i);
         end else begin
            check("full_ready_off", ld_ready_s, 0);
            check("full_no_write", mem_write_enable_s, 0);
         end
         if (i == 15) check("full_not_yet", load_full_s, 0);
      end
      #1;
      check("full_flag", load_full_s, 1);
      check("full_words", words_loaded_s, 16);
      check("full_run", core_hold_s, 0);
      ld_valid_s = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences the single-port instruction memory between two users: a boot/program loader stream that writes words, and the core fetch stage that reads them.
- After reset it holds the core, loads a program, then releases the core and serves registered fetches.
- A mid-run reprogram request re-enters the load phase.
- Sits between the core fetch stage, the UART/debug loader and the instruction memory.

Parameters:
- DATA_WIDTH, 32, instruction/word width.
- ADDR_WIDTH, 12, word-address width of the instruction memory; depth = 2**ADDR_WIDTH.
- NOP_INSTR, 32'h0000_0013, instruction returned on a faulted fetch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_WIDTH  loader word.
- ld_last  in  1  marks final word of the program, qualified by ld_valid.
- ld_ready  out  1  controller accepts the loader word this cycle.
- prog_req  in  1  request reprogram while running (level).
- fetch_req  in  1  core fetch request.
- fetch_addr  in  32  byte address of the fetch.
- fetch_valid  out  1  fetch_instr valid.
- fetch_instr  out  DATA_WIDTH  fetched instruction.
- fetch_fault  out  1  one-cycle pulse with fetch_valid for a misaligned or out-of-range fetch.
- core_hold  out  1  core must stall / hold PC.
- load_full  out  1  sticky: load ended by memory depth, not by ld_last.
- words_loaded  out  ADDR_WIDTH+1  words written in the last load.
- mem_read_enable  out  1  to instruction memory.
- mem_read_address  out  ADDR_WIDTH  to instruction memory.
- mem_read_data  in  DATA_WIDTH  combinational read data from instruction memory.
- mem_write_enable  out  1  to instruction memory.
- mem_write_address  out  ADDR_WIDTH  to instruction memory.
- mem_write_data  out  DATA_WIDTH  to instruction memory.

Behaviour:
- Reset (reset==0, async): state=LOAD, wr_ptr=0, words_loaded=0, load_full=0, fetch_valid=0, fetch_instr=0, fetch_fault=0, core_hold=1, ld_ready=0, all mem_* outputs 0.
- States: LOAD, RUN, DRAIN.

LOAD:
- core_hold=1, ld_ready=1 except in the first cycle after reset release (registered ready).
- Accepted word (ld_valid&ld_ready):
  - drive mem_write_enable=1, mem_write_address=wr_ptr, mem_write_data=ld_data combinationally;
  - wr_ptr++ and words_loaded=wr_ptr+1.
- On accepted ld_last: go to RUN next cycle, ld_ready=0 next cycle.
- If the accepted word is at wr_ptr==depth-1 without ld_last: write it, set load_full=1, go to RUN; wr_ptr never wraps.
- load_full clears on the first accepted word of a new load.
- fetch_req ignored; fetch_valid=0.

RUN:
- core_hold=0, ld_ready=0.
- Each fetch_req cycle: mem_read_enable=1, mem_read_address=fetch_addr[ADDR_WIDTH+1:2].
- Next cycle: fetch_valid=1, fetch_instr=mem_read_data (one-cycle latency, one result per request, back-to-back supported).
- Fetch faults (fetch_addr[1:0]!=0, or fetch_addr[31:ADDR_WIDTH+2]!=0): no memory read; next cycle fetch_valid=1, fetch_fault=1, fetch_instr=NOP_INSTR.
- fetch_addr at or beyond words_loaded but inside depth is not a fault; memory contents are returned.
- prog_req=1: go to DRAIN. The fetch accepted in that same cycle still completes.

DRAIN:
- core_hold=1, new fetch_req ignored.
- The pending fetch_valid, if any, is emitted this cycle.
- Then go to LOAD with wr_ptr=0 and words_loaded=0.

Other rules:
- Read and write are never driven in the same cycle: the state machine guarantees it.
- Reset mid-load: abandon the load, wr_ptr=0; memory contents are left as written.
- ld_valid while not in LOAD: held off (ld_ready=0); no data lost.

Decomposition:
- Package imem_ctrl_pkg: state enum (LOAD, RUN, DRAIN), NOP_INSTR constant, word-index helper function.
- Optional sub-module imem_fetch_port: address check plus the registered fetch response pipeline stage.

Test Plan:
- Reset, then load 4 words 0x11,0x22,0x33,0x44 with ld_last on the 4th -> writes at addresses 0..3, words_loaded=4, core_hold falls the cycle after the last write, load_full=0.
- RUN, fetch_req back-to-back at 0x0,0x4,0x8 -> fetch_valid on 3 consecutive cycles with 0x11,0x22,0x33, 1-cycle latency.
- Fetch at 0x6 and at 0x0000_4000 -> fetch_valid=1, fetch_fault=1, fetch_instr=0x00000013, mem_read_enable=0 in the request cycle.
- Load with ADDR_WIDTH=4 and 20 words, no ld_last -> 16 writes, load_full=1, ld_ready=0 for the remaining 4, words_loaded=16.
- prog_req in the same cycle as a fetch_req at 0x8 -> response 0x33 delivered, then core_hold=1 and LOAD; reload 2 words -> words_loaded=2, run resumes.
- Assert reset low mid-load after 2 of 5 words -> all outputs at reset values immediately (async); after release, the load restarts at address 0.
